// File: rtl/game_pkg.sv
// Shared screen ids, OLED geometry, FSM state type and saturating-counter helpers
// for the press/hold tutorial screens.
package game_pkg;

    localparam logic [2:0] SCR_TITLE = 3'd0;
    localparam logic [2:0] SCR_FAIL  = 3'd4;
    localparam logic [2:0] SCR_PRESS = 3'd5;
    localparam logic [2:0] SCR_HOLD  = 3'd6;
    localparam logic [2:0] SCR_DONE  = 3'd7;

    localparam int unsigned OLED_W      = 96;
    localparam int unsigned OLED_H      = 64;
    localparam int unsigned OLED_PIXELS = 6144;

    typedef enum logic [2:0] {
        StTitle,
        StPress,
        StHold,
        StFail,
        StDone
    } game_state_e;

    function automatic logic [2:0] state_screen(input game_state_e s);
        logic [2:0] scr;
        unique case (s)
            StTitle: scr = SCR_TITLE;
            StPress: scr = SCR_PRESS;
            StHold:  scr = SCR_HOLD;
            StFail:  scr = SCR_FAIL;
            StDone:  scr = SCR_DONE;
            default: scr = SCR_TITLE;
        endcase
        return scr;
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // True when the increment about to happen brings v up to lim.
    function automatic logic reach(input logic [15:0] v, input logic [15:0] lim);
        return ({1'b0, v} + 17'd1) >= {1'b0, lim};
    endfunction

endpackage

// File: rtl/game_screen_ctrl_btn_debounce.sv
// btn_debounce: 2-flop synchroniser, tick-sampled debouncer and single-cycle
// press/release pulses aligned with the first cycle of the new level.
module btn_debounce
    import game_pkg::*;
#(
    parameter int unsigned DEB_TICKS = 20
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick_1k,
    input  logic btn_raw,
    output logic btn_lvl,
    output logic press_ev,
    output logic rel_ev
);

    localparam logic [15:0] DebLim = 16'(DEB_TICKS);

    logic [1:0]  sync_q;
    logic        lvl_q, lvl_d;
    logic        press_q, press_d;
    logic        rel_q, rel_d;
    logic [15:0] cnt_q, cnt_d;
    logic        btn_sync;

    assign btn_sync = sync_q[1];

    always_comb begin
        cnt_d   = cnt_q;
        lvl_d   = lvl_q;
        press_d = 1'b0;
        rel_d   = 1'b0;
        if (tick_1k) begin
            if (btn_sync != lvl_q) begin
                if (reach(cnt_q, DebLim)) begin
                    lvl_d   = btn_sync;
                    cnt_d   = 16'd0;
                    press_d = btn_sync;
                    rel_d   = ~btn_sync;
                end else begin
                    cnt_d = sat_inc(cnt_q);
                end
            end else begin
                // Any agreeing tick restarts the stability window.
                cnt_d = 16'd0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= 2'b00;
            lvl_q   <= 1'b0;
            press_q <= 1'b0;
            rel_q   <= 1'b0;
            cnt_q   <= 16'd0;
        end else begin
            sync_q  <= {sync_q[0], btn_raw};
            lvl_q   <= lvl_d;
            press_q <= press_d;
            rel_q   <= rel_d;
            cnt_q   <= cnt_d;
        end
    end

    assign btn_lvl  = lvl_q;
    assign press_ev = press_q;
    assign rel_ev   = rel_q;

endmodule

// File: rtl/game_screen_ctrl.sv
// Press/hold tutorial screen sequencer for the 96x64 OLED: button FSM, frame-aligned
// screen select and pixel (x, y) decode. Optional macro: SCREEN_TIMEOUT_EN.
module game_screen_ctrl
    import game_pkg::*;
#(
    parameter int unsigned DEB_TICKS     = 20,
    parameter int unsigned HOLD_TICKS    = 1000,
    parameter int unsigned SHOW_TICKS    = 1500,
    parameter int unsigned TIMEOUT_TICKS = 10000
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        tick_1k,
    input  logic                        btn_c,
    input  logic [12:0]                 pixel_index,
    input  logic [15:0]                 pix_in,
    output logic [6:0]                  x,
    output logic [$clog2(OLED_H)-1:0]   y,
    output logic [2:0]                  screen_sel,
    output logic [15:0]                 oled_data,
    output logic                        done_pulse
);

    if (DEB_TICKS < 1 || DEB_TICKS > 65535 || HOLD_TICKS < 1 || HOLD_TICKS > 65535 ||
        SHOW_TICKS < 1 || SHOW_TICKS > 65535 || TIMEOUT_TICKS < 1 ||
        TIMEOUT_TICKS > 65535) begin : g_param_check
        $error("game_screen_ctrl: tick parameters must lie in 1..65535");
    end

    localparam logic [15:0] HoldLim = 16'(HOLD_TICKS);
    localparam logic [15:0] ShowLim = 16'(SHOW_TICKS);

    logic btn_lvl, press_ev, rel_ev;

    btn_debounce #(
        .DEB_TICKS (DEB_TICKS)
    ) u_deb (
        .clk      (clk),
        .rst_n    (rst_n),
        .tick_1k  (tick_1k),
        .btn_raw  (btn_c),
        .btn_lvl  (btn_lvl),
        .press_ev (press_ev),
        .rel_ev   (rel_ev)
    );

    game_state_e state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic        armed_q, armed_d;
    logic        timeout_hit;

`ifdef SCREEN_TIMEOUT_EN
    localparam logic [15:0] TimeoutLim = 16'(TIMEOUT_TICKS);
    logic [15:0] inact_q, inact_d;
    assign timeout_hit = tick_1k && reach(inact_q, TimeoutLim);
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        armed_d = armed_q;
`ifdef SCREEN_TIMEOUT_EN
        inact_d = inact_q;
        if (press_ev || rel_ev) begin
            inact_d = 16'd0;
        end else if (tick_1k) begin
            inact_d = sat_inc(inact_q);
        end
`endif
        unique case (state_q)
            StTitle: begin
                if (press_ev) state_d = StPress;
            end
            StPress: begin
                // Counter stops at HOLD_TICKS; a release after that is ignored.
                if (press_ev) begin
                    cnt_d = 16'd0;
                end else if (tick_1k && btn_lvl && (cnt_q < HoldLim)) begin
                    cnt_d = cnt_q + 16'd1;
                end
                if (timeout_hit) begin
                    state_d = StTitle;
                end else if (rel_ev && (cnt_q < HoldLim)) begin
                    state_d = StHold;
                end
            end
            StHold: begin
                // armed_q marks a press that began on this screen.
                if (press_ev) begin
                    cnt_d   = 16'd0;
                    armed_d = 1'b1;
                end else if (tick_1k && btn_lvl && armed_q) begin
                    if (reach(cnt_q, HoldLim)) begin
                        state_d = StDone;
                    end else begin
                        cnt_d = sat_inc(cnt_q);
                    end
                end
                if (state_d != StDone) begin
                    if (timeout_hit) begin
                        state_d = StTitle;
                    end else if (rel_ev && armed_q) begin
                        state_d = StFail;
                    end
                end
            end
            StFail, StDone: begin
                if (tick_1k) begin
                    if (reach(cnt_q, ShowLim)) begin
                        state_d = (state_q == StFail) ? StHold : StTitle;
                    end else begin
                        cnt_d = sat_inc(cnt_q);
                    end
                end
            end
            default: state_d = StTitle;
        endcase
        if (state_d != state_q) begin
            cnt_d   = 16'd0;
            armed_d = 1'b0;
`ifdef SCREEN_TIMEOUT_EN
            inact_d = 16'd0;
`endif
        end
    end

    // x = p mod 96, y = p / 96 via (p >> 5) * 171 >> 9, exact for p < 6144.
    logic [15:0]               p_hi, y_mul;
    logic [$clog2(OLED_H)-1:0] y_dec;
    logic [6:0]                x_dec;
    logic                      in_range;

    assign p_hi     = {8'd0, pixel_index[12:5]};
    assign y_mul    = (p_hi << 7) + (p_hi << 5) + (p_hi << 3) + (p_hi << 1) + p_hi;
    assign y_dec    = 6'(y_mul >> 9);
    assign x_dec    = 7'(pixel_index - {1'b0, y_dec, 6'b0} - {2'b0, y_dec, 5'b0});
    assign in_range = pixel_index < 13'(OLED_PIXELS);

    logic [6:0]  x_q;
    logic [5:0]  y_q;
    logic [2:0]  scr_q;
    logic [15:0] oled_q;
    logic        done_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StTitle;
            cnt_q   <= 16'd0;
            armed_q <= 1'b0;
            x_q     <= 7'd0;
            y_q     <= 6'd0;
            scr_q   <= SCR_TITLE;
            oled_q  <= 16'h0000;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            armed_q <= armed_d;
            x_q     <= in_range ? x_dec : 7'd0;
            y_q     <= in_range ? y_dec : 6'd0;
            oled_q  <= pix_in;
            done_q  <= (state_d == StDone) && (state_q != StDone);
            if (pixel_index == 13'd0) scr_q <= state_screen(state_q);
        end
    end

`ifdef SCREEN_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) inact_q <= 16'd0;
        else        inact_q <= inact_d;
    end
`endif

    assign x          = x_q;
    assign y          = y_q;
    assign screen_sel = scr_q;
    assign oled_data  = oled_q;
    assign done_pulse = done_q;

endmodule

// File: tb/tb_game_screen_ctrl.sv
// Scoreboard bench for game_screen_ctrl: pixel/colour pipeline and frame-aligned
// screen sequence through TITLE, PRESS, HOLD, FAIL, DONE and reset.
`timescale 1ns/1ps
module tb_game_screen_ctrl;
    import game_pkg::*;

    localparam int unsigned DEB = 4, HOLD = 20, SHOW = 30, TMO = 60, TICK_DIV = 5;

    logic        clk = 1'b0;
    logic        rst_n, tick_1k, btn_c;
    logic [12:0] pixel_index;
    logic [15:0] pix_in;
    logic [6:0]  x;
    logic [5:0]  y;
    logic [2:0]  screen_sel;
    logic [15:0] oled_data;
    logic        done_pulse;

    always #5 clk = ~clk;

    game_screen_ctrl #(
        .DEB_TICKS     (DEB),
        .HOLD_TICKS    (HOLD),
        .SHOW_TICKS    (SHOW),
        .TIMEOUT_TICKS (TMO)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .tick_1k     (tick_1k),
        .btn_c       (btn_c),
        .pixel_index (pixel_index),
        .pix_in      (pix_in),
        .x           (x),
        .y           (y),
        .screen_sel  (screen_sel),
        .oled_data   (oled_data),
        .done_pulse  (done_pulse)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    logic [12:0] xy_q[$];
    logic [15:0] col_q[$];
    logic [2:0]  scr_q[$];
    logic [12:0] pix_ovr[$];
    logic [2:0]  scr_prev = 3'd0;
    logic [12:0] last_pix = 13'd0;
    int pcnt = 0, frame_len = 6144, tdiv = 0;
    int n_press = 0, n_rel = 0, n_done = 0, done_ticks = 0, fail_ticks = 0;

    function automatic logic [15:0] render(input logic [6:0] rx, input logic [5:0] ry);
        return {rx, 3'b101, ry};
    endfunction

    task automatic step();
        logic [12:0] p, e;
        logic [6:0]  ex;
        logic [5:0]  ey;
        @(posedge clk);
        #1;
        if (rst_n) begin
            if (xy_q.size() > 0) begin
                e = xy_q.pop_front();
                check("x", x, e[12:6]);
                check("y", y, e[5:0]);
            end
            if (col_q.size() == 2) check("oled", oled_data, col_q.pop_front());
            if (screen_sel !== scr_prev) begin
                if (scr_q.size() == 0) check("scr_unexpected", screen_sel, scr_prev);
                else                   check("scr", screen_sel, scr_q.pop_front());
                check("scr_at_px0", last_pix, 0);
                scr_prev = screen_sel;
            end
            if (done_pulse)   n_done++;
            if (dut.press_ev) n_press++;
            if (dut.rel_ev)   n_rel++;
        end
        tick_1k = (tdiv == TICK_DIV - 1);
        tdiv    = (tdiv + 1) % TICK_DIV;
        if (tick_1k && rst_n) begin
            if (dut.state_q == StDone) done_ticks++;
            if (dut.state_q == StFail) fail_ticks++;
        end
        if (pix_ovr.size() > 0) begin
            p = pix_ovr.pop_front();
        end else begin
            p    = 13'(pcnt);
            pcnt = (pcnt + 1 >= frame_len) ? 0 : pcnt + 1;
        end
        pixel_index = p;
        last_pix    = p;
        pix_in      = render(x, y);
        if (rst_n) begin
            if (p < 13'd6144) begin
                ex = 7'(p % 96);
                ey = 6'(p / 96);
            end else begin
                ex = 7'd0;
                ey = 6'd0;
            end
            xy_q.push_back({ex, ey});
            col_q.push_back(render(ex, ey));
        end
    endtask

    task automatic run_ticks(input int n);
        repeat (n * TICK_DIV) step();
    endtask

    task automatic drain(input string tag, input int budget);
        int i = 0;
        while (scr_q.size() > 0 && i < budget) begin
            step();
            i++;
        end
        check(tag, scr_q.size(), 0);
        scr_q.delete();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        btn_c = 1'b0;
        xy_q.delete();
        col_q.delete();
        scr_q.delete();
        scr_prev = 3'd0;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_x"}, x, 0);
        check({tag, "_y"}, y, 0);
        check({tag, "_oled"}, oled_data, 0);
        check({tag, "_scr"}, screen_sel, 0);
        check({tag, "_done"}, done_pulse, 0);
        check({tag, "_state"}, dut.state_q, StTitle);
        check({tag, "_cnt"}, dut.cnt_q, 0);
        check({tag, "_lvl"}, dut.btn_lvl, 0);
    endtask

    initial begin
        tick_1k = 1'b0;
        pixel_index = 13'd0;
        pix_in = 16'd0;
        do_reset();
        repeat (3) step();
        check_reset_vals("rst");

        // Two idle full frames, then decode boundaries.
        pcnt  = 0;
        rst_n = 1'b1;
        repeat (2 * 6144 + 10) step();
        pix_ovr = '{13'd97, 13'd6143, 13'd6144, 13'd8191, 13'd95, 13'd96};
        repeat (10) step();
        check("idle_scr", screen_sel, SCR_TITLE);

        frame_len = 40;
        pcnt = 0;

        // Bounce shorter than the debounce window, then a clean press/release.
        for (int i = 0; i < 5; i++) begin
            btn_c = 1'b1;
            repeat (3) step();
            btn_c = 1'b0;
            repeat (4) step();
        end
        run_ticks(DEB + 2);
        check("bounce_press", n_press, 0);
        n_press = 0;
        n_rel   = 0;
        scr_q.push_back(SCR_PRESS);
        scr_q.push_back(SCR_HOLD);
        btn_c = 1'b1;
        run_ticks(DEB + 6);
        btn_c = 1'b0;
        run_ticks(DEB + 2);
        drain("to_hold", 400);
        check("one_press", n_press, 1);
        check("one_rel", n_rel, 1);
        check("st_hold", dut.state_q, StHold);

        // Full hold to DONE, then back to TITLE.
        n_done = 0;
        done_ticks = 0;
        scr_q.push_back(SCR_DONE);
        scr_q.push_back(SCR_TITLE);
        btn_c = 1'b1;
        run_ticks(DEB + HOLD + 3);
        btn_c = 1'b0;
        drain("done_title", 2000);
        check("done_pulses", n_done, 1);
        check("done_ticks", done_ticks, SHOW);
        check("st_title", dut.state_q, StTitle);

        // Idle (button held) on PRESS.
        scr_q.push_back(SCR_PRESS);
        btn_c = 1'b1;
`ifdef SCREEN_TIMEOUT_EN
        scr_q.push_back(SCR_TITLE);
        run_ticks(DEB + TMO + 8);
        drain("timeout_title", 400);
        check("st_timeout", dut.state_q, StTitle);
        btn_c = 1'b0;
        run_ticks(DEB + 2);
        check("st_title_rel", dut.state_q, StTitle);
        scr_q.push_back(SCR_PRESS);
`else
        run_ticks(DEB + 2 * TMO);
        drain("press_scr", 400);
        check("st_press_long", dut.state_q, StPress);
        check("press_sat", dut.cnt_q, HOLD);
        btn_c = 1'b0;
        run_ticks(DEB + 2);
        check("st_press_rel_ign", dut.state_q, StPress);
`endif
        scr_q.push_back(SCR_HOLD);
        btn_c = 1'b1;
        run_ticks(DEB + 8);
        btn_c = 1'b0;
        run_ticks(DEB + 3);
        drain("to_hold2", 400);
        check("st_hold2", dut.state_q, StHold);

        // Early release on HOLD: FAIL, then HOLD again with a cleared counter.
        fail_ticks = 0;
        scr_q.push_back(SCR_FAIL);
        scr_q.push_back(SCR_HOLD);
        btn_c = 1'b1;
        run_ticks(DEB + HOLD / 2);
        btn_c = 1'b0;
        drain("fail_hold", 1000);
        check("fail_ticks", fail_ticks, SHOW);
        check("st_hold3", dut.state_q, StHold);
        check("hold_cnt0", dut.cnt_q, 0);

        // Asynchronous reset mid-hold and mid-frame.
        btn_c = 1'b1;
        begin
            int i = 0;
            while (dut.cnt_q != 16'd14 && i < 2000) begin
                step();
                i++;
            end
        end
        check("cnt_reach14", dut.cnt_q, 14);
        #2;
        do_reset();
        #1;
        check_reset_vals("rst_mid");
        repeat (3) step();
        rst_n = 1'b1;
        repeat (2 * frame_len + 5) step();
        check("post_rst_scr", screen_sel, SCR_TITLE);
        check("post_rst_state", dut.state_q, StTitle);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
